cr_xp10_decomp_sdd_bank_ctrl: RTL and testbench
===============================================

Name: cr_xp10_decomp_sdd_bank_ctrl

Overview:
- Sequences ownership of the N_BANKS decode-table banks (bct/sat/slt sets) shared by the Huffman table fill (HTF) writer and the symbol decoder (LD lane decoder).
- HTF fills the bank at wr_ptr and retires it on complete. The decoder claims the bank at rd_ptr at start-of-block (SOB credit) and releases it at end-of-block (EOB credit).
- Provides the bank selects, the HTF backpressure, the decoder SOB credit, per-block error/format tagging and protocol-violation strobes.

Parameters:
- N_BANKS, 2, number of table banks; power of two, 1..4.
- BW, $clog2(N_BANKS) (min 1), bank index width; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- htf_sdd_complete_valid  in  1  HTF finished filling bank wr_bank.
- htf_sdd_complete_error  in  1  the table being completed is in error; qualified by complete_valid.
- htf_sdd_complete_fmt  in  htf_fmt_e  format of the completed table.
- decoder_sob_credit_used  in  1  decoder claims bank rd_bank.
- decoder_eob_credit_used  in  1  decoder releases bank rd_bank.
- wr_bank  out  BW  bank HTF writes.
- rd_bank  out  BW  bank decoder reads.
- sdd_htf_busy  out  1  bank[wr_ptr] not FREE; HTF must not write or complete.
- decoder_sob_credit_avail  out  1  bank[rd_ptr] is READY.
- rd_block_error  out  1  error tag of bank[rd_ptr].
- rd_block_fmt  out  htf_fmt_e  format tag of bank[rd_ptr].
- banks_used  out  $clog2(N_BANKS+1)  count of non-FREE banks.
- proto_err_stb  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Per-bank state: FREE(0), READY(1), ACTIVE(2). Filling is implicit: the bank at wr_ptr while it is FREE.
- Per-bank tags: err, fmt. Pointers wr_ptr and rd_ptr each wrap modulo N_BANKS.
- Reset (rst high at a clk edge):
  - all banks FREE, tags 0, wr_ptr = rd_ptr = 0;
  - outputs: wr_bank = 0, rd_bank = 0, sdd_htf_busy = 0, decoder_sob_credit_avail = 0, rd_block_error = 0, rd_block_fmt = 0, banks_used = 0, proto_err_stb = 0.
  - Reset mid-operation discards all banks immediately, including an ACTIVE bank.
- Outputs other than proto_err_stb are combinational decodes of registered state. An event at edge N is visible after edge N (1-cycle latency). proto_err_stb is registered and asserts the cycle after the offending request.
- complete_valid:
  - If bank[wr_ptr] is FREE: bank becomes READY, err/fmt are captured, wr_ptr increments.
  - Otherwise (busy): the request is ignored and proto_err_stb pulses.
- sob_used:
  - If bank[rd_ptr] is READY: bank becomes ACTIVE.
  - Otherwise: ignored and proto_err_stb pulses.
- eob_used:
  - If bank[rd_ptr] is ACTIVE: bank becomes FREE, tags clear, rd_ptr increments.
  - Otherwise: ignored and proto_err_stb pulses.
- At most one bank is ACTIVE, always the one at rd_ptr.
- All legality checks use pre-edge state:
  - sob and eob in the same cycle: eob is legal only if the bank is ACTIVE, in which case sob is illegal (the bank is not READY). Result: release plus error pulse.
  - complete and eob on the same bank in the same cycle (full ring, wr_ptr == rd_ptr): complete is rejected (bank not yet FREE) and the release proceeds.
  - complete and sob on different banks in the same cycle: both apply.
- banks_used = number of READY + ACTIVE banks. It updates by +1 / -1 / 0 on simultaneous accepted complete and eob.
- Full: banks_used == N_BANKS implies sdd_htf_busy = 1. Empty: banks_used == 0 implies decoder_sob_credit_avail = 0.
- N_BANKS = 1: both pointers are stuck at 0 and the block degenerates to single-buffered.
- Multiple illegal events in one cycle produce a single pulse.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, banks_used = 0.
- N_BANKS = 2: complete (fmt = 1, err = 0) at cycle 1, complete (err = 1) at cycle 3 -> cycle 4: sdd_htf_busy = 1, banks_used = 2, wr_bank = 0. decoder_sob_credit_avail = 1 with rd_bank = 0, rd_block_fmt = 1, rd_block_error = 0.
- Continue: sob then eob -> rd_bank = 1, rd_block_error = 1, sdd_htf_busy = 0, banks_used = 1. A further complete is accepted into bank 0.
- Full ring with bank 0 ACTIVE: complete + eob in the same cycle -> eob accepted, complete rejected, proto_err_stb = 1 for one cycle, banks_used = 1.
- eob with no ACTIVE bank and sob with an empty ring -> proto_err_stb pulses each time, state unchanged.
- rst asserted while bank 0 is ACTIVE and bank 1 is READY -> next cycle all FREE, pointers 0, outputs 0.

Source files
------------

// File: rtl/cr_xp10_decomp_sdd_bank_ctrl.sv
// Decode-table bank ownership sequencer between HTF fill and decoder.
// Banks cycle FREE -> READY -> ACTIVE -> FREE around a pointer ring.
package cr_xp10_decomp_sdd_pkg;
  typedef enum logic [1:0] {
    FMT_XP10    = 2'd0,
    FMT_XP9     = 2'd1,
    FMT_ZLIB    = 2'd2,
    FMT_DEFLATE = 2'd3
  } htf_fmt_e;
endpackage

module cr_xp10_decomp_sdd_bank_ctrl
  import cr_xp10_decomp_sdd_pkg::*;
#(
  parameter int N_BANKS = 2,
  localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int UW = $clog2(N_BANKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          htf_sdd_complete_valid,
  input  logic          htf_sdd_complete_error,
  input  htf_fmt_e      htf_sdd_complete_fmt,
  input  logic          decoder_sob_credit_used,
  input  logic          decoder_eob_credit_used,
  output logic [BW-1:0] wr_bank,
  output logic [BW-1:0] rd_bank,
  output logic          sdd_htf_busy,
  output logic          decoder_sob_credit_avail,
  output logic          rd_block_error,
  output htf_fmt_e      rd_block_fmt,
  output logic [UW-1:0] banks_used,
  output logic          proto_err_stb
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    READY  = 2'd1,
    ACTIVE = 2'd2
  } bank_st_e;

  bank_st_e      st   [N_BANKS];
  bank_st_e      st_n [N_BANKS];
  logic          err  [N_BANKS];
  logic          err_n[N_BANKS];
  htf_fmt_e      fmt  [N_BANKS];
  htf_fmt_e      fmt_n[N_BANKS];
  logic [BW-1:0] wr_ptr, wr_n;
  logic [BW-1:0] rd_ptr, rd_n;
  logic          perr, perr_n;

  logic c_ok, s_ok, e_ok;
  logic c_bad, s_bad, e_bad;

  function automatic logic [BW-1:0] inc(input logic [BW-1:0] p);
    return (p == BW'(N_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Legality of each request, judged on pre-edge bank state
  always_comb begin
    c_ok  = htf_sdd_complete_valid && (st[wr_ptr] == FREE);
    s_ok  = decoder_sob_credit_used && (st[rd_ptr] == READY);
    e_ok  = decoder_eob_credit_used && (st[rd_ptr] == ACTIVE);
    c_bad = htf_sdd_complete_valid && !c_ok;
    s_bad = decoder_sob_credit_used && !s_ok;
    e_bad = decoder_eob_credit_used && !e_ok;
  end

  // Next bank state, tags, pointers and violation strobe
  always_comb begin
    st_n   = st;
    err_n  = err;
    fmt_n  = fmt;
    wr_n   = wr_ptr;
    rd_n   = rd_ptr;
    perr_n = c_bad || s_bad || e_bad;
    if (c_ok) begin
      st_n[wr_ptr]  = READY;
      err_n[wr_ptr] = htf_sdd_complete_error;
      fmt_n[wr_ptr] = htf_sdd_complete_fmt;
      wr_n          = inc(wr_ptr);
    end
    if (s_ok) begin
      st_n[rd_ptr] = ACTIVE;
    end
    if (e_ok) begin
      st_n[rd_ptr]  = FREE;
      err_n[rd_ptr] = 1'b0;
      fmt_n[rd_ptr] = FMT_XP10;
      rd_n          = inc(rd_ptr);
    end
  end

  // State register; reset discards every bank, active or not
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BANKS; i++) begin
        st[i]  <= FREE;
        err[i] <= 1'b0;
        fmt[i] <= FMT_XP10;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      perr   <= 1'b0;
    end else begin
      st     <= st_n;
      err    <= err_n;
      fmt    <= fmt_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      perr   <= perr_n;
    end
  end

  // Occupancy: banks held by a table (READY or ACTIVE)
  always_comb begin
    banks_used = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (st[i] != FREE) banks_used = banks_used + UW'(1);
    end
  end

  assign wr_bank                  = wr_ptr;
  assign rd_bank                  = rd_ptr;
  assign sdd_htf_busy             = (st[wr_ptr] != FREE);
  assign decoder_sob_credit_avail = (st[rd_ptr] == READY);
  assign rd_block_error           = err[rd_ptr];
  assign rd_block_fmt             = fmt[rd_ptr];
  assign proto_err_stb            = perr;

endmodule

// File: tb/tb_cr_xp10_decomp_sdd_bank_ctrl.sv
// Bench for the SDD bank controller: FIFO-of-blocks reference model
// checked every cycle, plus literal checkpoints from the test plan.
module tb_cr_xp10_decomp_sdd_bank_ctrl;
  import cr_xp10_decomp_sdd_pkg::*;

  localparam int N  = 2;
  localparam int BW = 1;
  localparam int UW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cv = 1'b0;
  logic          ce = 1'b0;
  htf_fmt_e      cf = FMT_XP10;
  logic          sob = 1'b0;
  logic          eob = 1'b0;
  logic [BW-1:0] wr_bank, rd_bank;
  logic          busy, avail, rerr, perr;
  htf_fmt_e      rfmt;
  logic [UW-1:0] used;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  cr_xp10_decomp_sdd_bank_ctrl #(.N_BANKS(N)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .htf_sdd_complete_valid   (cv),
    .htf_sdd_complete_error   (ce),
    .htf_sdd_complete_fmt     (cf),
    .decoder_sob_credit_used  (sob),
    .decoder_eob_credit_used  (eob),
    .wr_bank                  (wr_bank),
    .rd_bank                  (rd_bank),
    .sdd_htf_busy             (busy),
    .decoder_sob_credit_avail (avail),
    .rd_block_error           (rerr),
    .rd_block_fmt             (rfmt),
    .banks_used               (used),
    .proto_err_stb            (perr)
  );

  always #5 clk = ~clk;

  // Model: the ring is a FIFO of filled blocks; the head may be claimed.
  typedef struct {
    logic     e;
    htf_fmt_e f;
  } blk_t;

  blk_t q[$];
  bit   m_act  = 1'b0;
  int   m_wrc  = 0;
  int   m_rdc  = 0;
  bit   m_perr = 1'b0;

  always @(posedge clk) begin
    bit c_ok, s_ok, e_ok;
    blk_t b;
    if (rst) begin
      q.delete();
      m_act  = 1'b0;
      m_wrc  = 0;
      m_rdc  = 0;
      m_perr = 1'b0;
    end else begin
      c_ok = cv && (q.size() < N);
      s_ok = sob && (q.size() > 0) && !m_act;
      e_ok = eob && m_act;
      m_perr = (cv && !c_ok) || (sob && !s_ok) || (eob && !e_ok);
      if (e_ok) begin
        void'(q.pop_front());
        m_act = 1'b0;
        m_rdc++;
      end
      if (s_ok) m_act = 1'b1;
      if (c_ok) begin
        b.e = ce;
        b.f = cf;
        q.push_back(b);
        m_wrc++;
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_wr_bank", wr_bank, m_wrc % N);
      cmp("m_rd_bank", rd_bank, m_rdc % N);
      cmp("m_used", used, q.size());
      cmp("m_busy", busy, q.size() == N);
      cmp("m_avail", avail, (q.size() > 0) && !m_act);
      cmp("m_rerr", rerr, (q.size() > 0) ? int'(q[0].e) : 0);
      cmp("m_rfmt", rfmt, (q.size() > 0) ? int'(q[0].f) : 0);
      cmp("m_perr", perr, m_perr);
    end
  end

  task automatic cyc(input logic c, input logic e, input htf_fmt_e f,
                     input logic s, input logic eb);
    cv  = c;
    ce  = e;
    cf  = f;
    sob = s;
    eob = eb;
    @(posedge clk);
    #1;
    cv  = 1'b0;
    ce  = 1'b0;
    cf  = FMT_XP10;
    sob = 1'b0;
    eob = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, FMT_XP10, 0, 0);
  endtask

  task automatic all_zero(input string tag);
    cmp({tag, "_wr"}, wr_bank, 0);
    cmp({tag, "_rd"}, rd_bank, 0);
    cmp({tag, "_busy"}, busy, 0);
    cmp({tag, "_avail"}, avail, 0);
    cmp({tag, "_rerr"}, rerr, 0);
    cmp({tag, "_rfmt"}, rfmt, 0);
    cmp({tag, "_used"}, used, 0);
    cmp({tag, "_perr"}, perr, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(5);
    all_zero("reset");

    // Fill both banks
    cyc(1, 0, FMT_XP9, 0, 0);
    cmp("c1_used", used, 1);
    cmp("c1_wr", wr_bank, 1);
    cmp("c1_avail", avail, 1);
    idle(1);
    cyc(1, 1, FMT_ZLIB, 0, 0);
    cmp("full_busy", busy, 1);
    cmp("full_used", used, 2);
    cmp("full_wr", wr_bank, 0);
    cmp("full_avail", avail, 1);
    cmp("full_rd", rd_bank, 0);
    cmp("full_fmt", rfmt, 1);
    cmp("full_err", rerr, 0);

    // Claim and release bank 0
    cyc(0, 0, FMT_XP10, 1, 0);
    cmp("sob_avail", avail, 0);
    cmp("sob_used", used, 2);
    cyc(0, 0, FMT_XP10, 0, 1);
    cmp("eob_rd", rd_bank, 1);
    cmp("eob_err", rerr, 1);
    cmp("eob_fmt", rfmt, 2);
    cmp("eob_busy", busy, 0);
    cmp("eob_used", used, 1);

    // Refill bank 0
    cyc(1, 0, FMT_DEFLATE, 0, 0);
    cmp("refill_wr", wr_bank, 1);
    cmp("refill_used", used, 2);
    cmp("refill_busy", busy, 1);
    cmp("refill_perr", perr, 0);

    // Full ring, head ACTIVE: complete + eob together
    cyc(0, 0, FMT_XP10, 1, 0);
    cyc(1, 1, FMT_XP9, 0, 1);
    cmp("ce_perr", perr, 1);
    cmp("ce_used", used, 1);
    cmp("ce_rd", rd_bank, 0);
    cmp("ce_wr", wr_bank, 1);
    cmp("ce_fmt", rfmt, 3);
    idle(1);
    cmp("ce_perr_drop", perr, 0);

    // eob with nothing ACTIVE
    cyc(0, 0, FMT_XP10, 0, 1);
    cmp("eob_bad_perr", perr, 1);
    cmp("eob_bad_used", used, 1);
    idle(1);

    // Drain, then sob on an empty ring
    cyc(0, 0, FMT_XP10, 1, 0);
    cyc(0, 0, FMT_XP10, 0, 1);
    cmp("drain_used", used, 0);
    cyc(0, 0, FMT_XP10, 1, 0);
    cmp("sob_empty_perr", perr, 1);
    cmp("sob_empty_avail", avail, 0);
    cmp("sob_empty_used", used, 0);
    idle(1);

    // sob + eob same cycle on ACTIVE head
    cyc(1, 0, FMT_ZLIB, 0, 0);
    cyc(0, 0, FMT_XP10, 1, 0);
    cyc(0, 0, FMT_XP10, 1, 1);
    cmp("se_perr", perr, 1);
    cmp("se_used", used, 0);
    cmp("se_rd", rd_bank, 0);
    idle(1);

    // Reset with bank 0 ACTIVE and bank 1 READY
    cyc(1, 1, FMT_XP9, 0, 0);
    cyc(1, 0, FMT_ZLIB, 1, 0);
    cmp("pre_rst_used", used, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    all_zero("midrst");

    // Pseudo-random traffic against the model
    for (int i = 0; i < 200; i++) begin
      cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          htf_fmt_e'($urandom_range(0, 3)),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    end
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
